// File: rtl/uart_tx_fifo.sv
// UART transmitter: 8N1 framing fed by a small byte FIFO so a producer can queue
// several bytes ahead of the serial shifter. Back-to-back frames run with no idle gap.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int                PTR_W       = $clog2(FIFO_DEPTH);
    localparam int                CNT_W       = PTR_W + 1;
    localparam logic [15:0]       BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [15:0]      baud_q, baud_d;
    logic             tx_q, tx_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             baud_done;

    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign tx_ready   = !rst && !fifo_full;
    assign push       = tx_valid && tx_ready;
    assign baud_done  = (baud_q == '0);

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) || !fifo_empty;

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        pop       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = BAUD_RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    // Chain straight into the next start bit when more bytes are waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = BAUD_RELOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is decoded from the next state so the line itself comes straight off a flop.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; cnt_q guards every read,
    // and leaving it out of reset lets it map onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-level reference model predicts
// tx, busy and tx_ready every cycle while directed and random stimulus runs.
module tb_uart_tx_fifo;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model: queue of waiting bytes plus the frame currently on the line.
    logic [7:0] m_q[$];
    bit         m_act = 1'b0;
    logic [7:0] m_cur = 8'h00;
    int         m_t = 0;
    bit         m_acc = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int t);
        int i;
        i = t / CPB;
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic model_edge();
        bit have;
        bit push;
        m_acc = 1'b0;
        if (rst === 1'b1) begin
            m_q.delete();
            m_act = 1'b0;
            m_t   = 0;
        end else begin
            have = (m_q.size() > 0);
            push = (tx_valid === 1'b1) && (m_q.size() < DEPTH);
            if (!m_act) begin
                if (have) begin
                    m_cur = m_q.pop_front();
                    m_act = 1'b1;
                    m_t   = 0;
                end
            end else if (m_t == FRAME_LEN - 1) begin
                if (have) begin
                    m_cur = m_q.pop_front();
                    m_t   = 0;
                end else begin
                    m_act = 1'b0;
                    m_t   = 0;
                end
            end else begin
                m_t++;
            end
            if (push) begin
                m_q.push_back(tx_data);
                m_acc = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_tx;
        logic exp_busy;
        logic exp_ready;
        exp_tx    = m_act ? frame_bit(m_cur, m_t) : 1'b1;
        exp_busy  = m_act || (m_q.size() != 0);
        exp_ready = (rst !== 1'b1) && (m_q.size() < DEPTH);
        tests_run++;
        assert (tx === exp_tx) else begin
            tests_failed++;
            $error("FAIL tx at %0t: observed %b expected %b", $time, tx, exp_tx);
        end
        tests_run++;
        assert (busy === exp_busy) else begin
            tests_failed++;
            $error("FAIL busy at %0t: observed %b expected %b", $time, busy, exp_busy);
        end
        tests_run++;
        assert (tx_ready === exp_ready) else begin
            tests_failed++;
            $error("FAIL tx_ready at %0t: observed %b expected %b", $time, tx_ready, exp_ready);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check at negedge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        tx_valid = v;
        tx_data  = d;
        rst      = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'($urandom), 1'b0);
    endtask

    initial begin
        logic [7:0] vals [6];
        int idx;
        int budget;

        // Reset held for a few edges; tx_ready must stay low throughout.
        for (int k = 0; k < 3; k++) step(1'b1, 8'h5A, 1'b1);
        idle_cycles(2);

        // Single byte: one 40-cycle frame, then idle.
        step(1'b1, 8'hA5, 1'b0);
        idle_cycles(45);

        // Three bytes on consecutive cycles: three gapless frames.
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        idle_cycles(FRAME_LEN * 3 + 5);

        // Hold tx_valid through backpressure; data changes only once accepted.
        for (int k = 0; k < 6; k++) vals[k] = 8'(k + 1);
        idx = 0;
        budget = 0;
        while (idx < 6 && budget < 400) begin
            step(1'b1, vals[idx], 1'b0);
            if (m_acc) idx++;
            budget++;
        end
        tests_run++;
        assert (idx == 6) else begin
            tests_failed++;
            $error("FAIL backpressure_accept: observed %0d bytes accepted expected 6", idx);
        end
        idle_cycles(FRAME_LEN * 6 + 5);

        // Ignored bytes: tx_valid with tx_ready low must not enqueue differing data.
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h30 + k), 1'b0);
        for (int k = 0; k < 20; k++) step(1'b1, 8'hEE, 1'b0);
        idle_cycles(FRAME_LEN * 6);

        // Reset mid-frame at cycle 17 of 8'hC3 with two bytes queued.
        step(1'b1, 8'hC3, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        budget = 0;
        while (!(m_act && m_t == 17) && budget < 100) begin
            step(1'b0, 8'h00, 1'b0);
            budget++;
        end
        tests_run++;
        assert (m_act && m_t == 17) else begin
            tests_failed++;
            $error("FAIL reset_align: observed t=%0d expected 17", m_t);
        end
        step(1'b0, 8'h00, 1'b1);
        idle_cycles(FRAME_LEN + 10);

        // Push at the STOP->START pop edge with the FIFO one short of full.
        step(1'b1, 8'h81, 1'b0);
        step(1'b1, 8'h82, 1'b0);
        step(1'b1, 8'h83, 1'b0);
        step(1'b1, 8'h84, 1'b0);
        budget = 0;
        while (!(m_act && m_t == FRAME_LEN - 1) && budget < 100) begin
            step(1'b0, 8'h00, 1'b0);
            budget++;
        end
        tests_run++;
        assert (m_act && m_q.size() == DEPTH - 1) else begin
            tests_failed++;
            $error("FAIL pop_push_setup: observed depth %0d expected %0d", m_q.size(), DEPTH - 1);
        end
        step(1'b1, 8'h85, 1'b0);
        idle_cycles(FRAME_LEN * 5);

        // Random traffic.
        for (int k = 0; k < 600; k++) step(1'(($urandom % 3) == 0), 8'($urandom), 1'b0);
        idle_cycles(FRAME_LEN * 5 + 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
